// File: rtl/six_digit_to_number_pkg.sv
// Shared constants, state encoding and character-class payload for the
// ASCII decimal field parser.
package six_digit_to_number_pkg;

  localparam int unsigned MAX_DIGITS_DEF = 6;
  localparam int unsigned OUT_W_DEF      = 32;
  localparam int unsigned CHAR_W         = 8;
  localparam int unsigned DIGIT_W        = 4;
  localparam int unsigned CNT_W          = 3;

  localparam logic [CHAR_W-1:0] ASCII_ZERO  = 8'h30;
  localparam logic [CHAR_W-1:0] ASCII_NINE  = 8'h39;
  localparam logic [CHAR_W-1:0] ASCII_SPACE = 8'h20;
  localparam logic [CHAR_W-1:0] ASCII_CR    = 8'h0D;
  localparam logic [CHAR_W-1:0] ASCII_LF    = 8'h0A;
  localparam logic [CHAR_W-1:0] ASCII_COMMA = 8'h2C;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCUM   = 2'd1,
    ST_DISCARD = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // Classification of one received character
  typedef struct packed {
    logic               is_digit;
    logic               is_term;
    logic [DIGIT_W-1:0] value;
  } char_class_t;

endpackage

// File: rtl/six_digit_to_number_ascii_to_number.sv
// Combinational character classifier: ASCII digit to 4-bit value plus
// digit/terminator flags (inverse of the number-to-ASCII helper).
module ascii_to_number
  import six_digit_to_number_pkg::*;
(
  input  logic [CHAR_W-1:0] i_char,
  output char_class_t       o_class_c
);

  always_comb begin
    o_class_c = '0;
    if ((i_char >= ASCII_ZERO) && (i_char <= ASCII_NINE)) begin
      o_class_c.is_digit = 1'b1;
      o_class_c.value    = DIGIT_W'(i_char - ASCII_ZERO);
    end
    o_class_c.is_term = (i_char == ASCII_SPACE) || (i_char == ASCII_CR) ||
                        (i_char == ASCII_LF)    || (i_char == ASCII_COMMA);
  end

endmodule

// File: rtl/six_digit_to_number.sv
// Streaming ASCII decimal parser: accumulates up to MAX_DIGITS digits MSB
// first and emits the binary value (or an error) on a terminator.
module six_digit_to_number
  import six_digit_to_number_pkg::*;
#(
  parameter int unsigned MAX_DIGITS = MAX_DIGITS_DEF,
  parameter int unsigned OUT_W      = OUT_W_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [CHAR_W-1:0] char_in,
  input  logic              char_valid,
  output logic              char_ready,
  output logic [OUT_W-1:0]  number,
  output logic [CNT_W-1:0]  digit_count,
  output logic              number_err,
  output logic              number_valid,
  input  logic              number_ready
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [OUT_W-1:0]   r_acc;
  logic [OUT_W-1:0]   w_acc_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               r_err;
  logic               w_err_nxt;
  logic               r_char_ready;
  logic               w_char_ready_nxt;
  logic [OUT_W-1:0]   r_number;
  logic [OUT_W-1:0]   w_number_nxt;
  logic [CNT_W-1:0]   r_digit_count;
  logic [CNT_W-1:0]   w_digit_count_nxt;
  logic               r_number_err;
  logic               w_number_err_nxt;
  logic               r_number_valid;
  logic               w_number_valid_nxt;

  char_class_t        w_class;
  logic               w_char_fire;
  logic               w_cnt_full;
  logic [OUT_W-1:0]   w_acc_times10;

  ascii_to_number u_ascii_to_number (
    .i_char    (char_in),
    .o_class_c (w_class)
  );

  assign w_char_fire   = char_valid && r_char_ready;
  assign w_cnt_full    = (r_cnt >= CNT_W'(MAX_DIGITS));
  // acc*10 as two shifts and an add, no multiplier
  assign w_acc_times10 = (r_acc << 3) + (r_acc << 1);

  // State and datapath registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= ST_IDLE;
      r_acc          <= '0;
      r_cnt          <= '0;
      r_err          <= 1'b0;
      r_char_ready   <= 1'b1;
      r_number       <= '0;
      r_digit_count  <= '0;
      r_number_err   <= 1'b0;
      r_number_valid <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_acc          <= w_acc_nxt;
      r_cnt          <= w_cnt_nxt;
      r_err          <= w_err_nxt;
      r_char_ready   <= w_char_ready_nxt;
      r_number       <= w_number_nxt;
      r_digit_count  <= w_digit_count_nxt;
      r_number_err   <= w_number_err_nxt;
      r_number_valid <= w_number_valid_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_char_fire) begin
          if (w_class.is_digit)     w_state_nxt = ST_ACCUM;
          else if (!w_class.is_term) w_state_nxt = ST_DISCARD;
        end
      end
      ST_ACCUM: begin
        if (w_char_fire) begin
          if (w_class.is_digit)     w_state_nxt = w_cnt_full ? ST_DISCARD : ST_ACCUM;
          else if (w_class.is_term) w_state_nxt = ST_DONE;
          else                      w_state_nxt = ST_DISCARD;
        end
      end
      ST_DISCARD: begin
        if (w_char_fire && w_class.is_term) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (number_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    w_acc_nxt          = r_acc;
    w_cnt_nxt          = r_cnt;
    w_err_nxt          = r_err;
    w_number_nxt       = r_number;
    w_digit_count_nxt  = r_digit_count;
    w_number_err_nxt   = r_number_err;
    w_number_valid_nxt = r_number_valid;
    w_char_ready_nxt   = (w_state_nxt != ST_DONE);
    case (r_state)
      ST_IDLE: begin
        if (w_char_fire) begin
          if (w_class.is_digit) begin
            w_acc_nxt = OUT_W'(w_class.value);
            w_cnt_nxt = CNT_W'(1);
          end else if (!w_class.is_term) begin
            w_err_nxt = 1'b1;
          end
        end
      end
      ST_ACCUM: begin
        if (w_char_fire) begin
          if (w_class.is_digit && !w_cnt_full) begin
            w_acc_nxt = w_acc_times10 + OUT_W'(w_class.value);
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end else if (w_class.is_term) begin
            w_number_nxt       = r_acc;
            w_digit_count_nxt  = r_cnt;
            w_number_err_nxt   = 1'b0;
            w_number_valid_nxt = 1'b1;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      ST_DISCARD: begin
        if (w_char_fire && w_class.is_term) begin
          w_number_nxt       = '0;
          w_digit_count_nxt  = '0;
          w_number_err_nxt   = r_err;
          w_number_valid_nxt = 1'b1;
        end
      end
      ST_DONE: begin
        // Result stays on the bus after the handshake; only valid drops
        if (number_ready) begin
          w_number_valid_nxt = 1'b0;
          w_acc_nxt          = '0;
          w_cnt_nxt          = '0;
          w_err_nxt          = 1'b0;
        end
      end
      default: begin
        w_err_nxt = 1'b0;
      end
    endcase
  end

  assign char_ready   = r_char_ready;
  assign number       = r_number;
  assign digit_count  = r_digit_count;
  assign number_err   = r_number_err;
  assign number_valid = r_number_valid;

endmodule
